// File: rtl/spi_arbiter.sv
// spi_arbiter: shares a single SPI master between two requesters.
// Round-robin selection on contention, one transaction in flight at a time,
// with a WAIT-state watchdog that returns an all-ones error frame on expiry.
module spi_arbiter #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 1024  // cycles spent in WAIT before abort, >= 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req0_ready,
  output logic              req1_ready,
  output logic              resp0_valid,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic              spi_start,
  output logic [DATA_W-1:0] spi_tx,
  input  logic              spi_done,
  input  logic [DATA_W-1:0] spi_rx,
  output logic [1:0]        grant
);

  localparam int CNT_W = $clog2(TIMEOUT);
  // WAIT cycles are counted from 0; the abort decision is taken in the cycle
  // whose incremented count reaches TIMEOUT-1, so RESP lands exactly TIMEOUT
  // cycles after the spi_start pulse.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

  state_t            r_state, w_next;
  logic              r_owner;   // 0: req0 owns the bus, 1: req1
  logic              r_last;    // requester served most recently
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_tx;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  logic w_accept;  // a request is accepted this cycle
  logic w_sel;     // which requester is accepted
  logic w_done;    // completion captured this cycle
  logic w_tmo;     // watchdog expiry this cycle (only when no spi_done)

  assign spi_tx    = r_tx;
  assign resp_data = r_rdata;
  assign resp_err  = r_err;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and handshake outputs; ready is masked during reset so a
  // request is never acknowledged without being latched.
  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_sel       = 1'b0;
    w_done      = 1'b0;
    w_tmo       = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    spi_start   = 1'b0;
    grant       = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (!reset && (req0_valid || req1_valid)) begin
          w_accept = 1'b1;
          // On contention the requester not served last wins
          if (req0_valid && req1_valid) w_sel = ~r_last;
          else                          w_sel = req1_valid;
          req0_ready = ~w_sel;
          req1_ready = w_sel;
          w_next     = S_START;
        end
      end
      S_START: begin
        spi_start = 1'b1;
        grant     = r_owner ? 2'b10 : 2'b01;
        w_next    = S_WAIT;
      end
      S_WAIT: begin
        grant = r_owner ? 2'b10 : 2'b01;
        // Completion takes priority over a coincident watchdog expiry
        if (spi_done) begin
          w_done = 1'b1;
          w_next = S_RESP;
        end else if (r_cnt == CNT_LAST) begin
          w_tmo  = 1'b1;
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        grant       = r_owner ? 2'b10 : 2'b01;
        resp0_valid = ~r_owner;
        resp1_valid = r_owner;
        w_next      = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: latch owner/frame on accept, run watchdog, capture response
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_cnt   <= '0;
      r_tx    <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_owner <= w_sel;
        r_tx    <= w_sel ? req1_data : req0_data;
      end
      if (r_state == S_START)     r_cnt <= '0;
      else if (r_state == S_WAIT) r_cnt <= r_cnt + CNT_W'(1);
      if (w_done) begin
        r_rdata <= spi_rx;
        r_err   <= 1'b0;
      end else if (w_tmo) begin
        r_rdata <= '1;
        r_err   <= 1'b1;
      end
      if (r_state == S_RESP) r_last <= r_owner;
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter. u_dut runs with TIMEOUT=8 for the
// arbitration/timeout/reset scenarios; u_big keeps the default TIMEOUT so a
// 10-cycle SPI transfer completes without tripping the watchdog.
module tb_spi_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_data, req1_data;
  logic        req0_ready, req1_ready, resp0_valid, resp1_valid;
  logic [15:0] resp_data;
  logic        resp_err, spi_start;
  logic [15:0] spi_tx;
  logic        spi_done;
  logic [15:0] spi_rx;
  logic [1:0]  grant;

  logic        b_req0_valid, b_req1_valid;
  logic [15:0] b_req0_data, b_req1_data;
  logic        b_req0_ready, b_req1_ready, b_resp0_valid, b_resp1_valid;
  logic [15:0] b_resp_data;
  logic        b_resp_err, b_spi_start;
  logic [15:0] b_spi_tx;
  logic        b_spi_done;
  logic [15:0] b_spi_rx;
  logic [1:0]  b_grant;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  spi_arbiter #(.DATA_W(16), .TIMEOUT(8)) u_dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_data(req0_data), .req1_data(req1_data),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
    .resp_data(resp_data), .resp_err(resp_err),
    .spi_start(spi_start), .spi_tx(spi_tx),
    .spi_done(spi_done), .spi_rx(spi_rx), .grant(grant)
  );

  spi_arbiter u_big (
    .clk(clk), .reset(reset),
    .req0_valid(b_req0_valid), .req1_valid(b_req1_valid),
    .req0_data(b_req0_data), .req1_data(b_req1_data),
    .req0_ready(b_req0_ready), .req1_ready(b_req1_ready),
    .resp0_valid(b_resp0_valid), .resp1_valid(b_resp1_valid),
    .resp_data(b_resp_data), .resp_err(b_resp_err),
    .spi_start(b_spi_start), .spi_tx(b_spi_tx),
    .spi_done(b_spi_done), .spi_rx(b_spi_rx), .grant(b_grant)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // One transaction on u_dut with a response after one WAIT cycle.
  // Expects the given requester to be accepted in the current IDLE cycle.
  task automatic xact(input logic sel, input logic [15:0] exp_tx, input logic [15:0] rx);
    #1;
    chk("rr_ready", {30'd0, req1_ready, req0_ready}, sel ? 32'd2 : 32'd1);
    tick();
    #1;
    chk("rr_start", {15'd0, spi_start, spi_tx}, {15'd0, 1'b1, exp_tx});
    chk("rr_noready", {30'd0, req1_ready, req0_ready}, 32'd0);
    tick();
    spi_done = 1'b1;
    spi_rx   = rx;
    tick();
    spi_done = 1'b0;
    #1;
    chk("rr_resp", {14'd0, resp1_valid, resp0_valid, resp_data},
        {14'd0, sel, ~sel, rx});
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1);
  end

  initial begin
    int seen;
    logic any_resp;
    reset = 1'b1;
    req0_valid = 0; req1_valid = 0; req0_data = '0; req1_data = '0;
    spi_done = 0; spi_rx = '0;
    b_req0_valid = 0; b_req1_valid = 0; b_req0_data = '0; b_req1_data = '0;
    b_spi_done = 0; b_spi_rx = '0;

    // Reset values
    tick(); tick();
    chk("rst_ctl", {26'd0, grant, spi_start, req0_ready, req1_ready, resp0_valid, resp1_valid},
        32'd0);
    chk("rst_data", {15'd0, resp_err, resp_data}, 32'd0);
    chk("rst_tx", {16'd0, spi_tx}, 32'd0);
    reset = 1'b0;
    tick();

    // Stray spi_done in IDLE is ignored
    spi_done = 1'b1; spi_rx = 16'hBEEF;
    tick();
    spi_done = 1'b0;
    #1;
    chk("stray", {13'd0, grant, resp0_valid, resp_data}, 32'd0);
    tick();
    chk("stray_idle", {29'd0, spi_start, grant}, 32'd0);

    // Single req0 on default-TIMEOUT instance, SPI returns 10 cycles later
    b_req0_valid = 1'b1; b_req0_data = 16'hA5C3;
    #1;
    chk("big_ready", {31'd0, b_req0_ready}, 32'd1);
    tick();
    b_req0_valid = 1'b0;
    #1;
    chk("big_start", {13'd0, b_spi_start, b_grant, b_spi_tx}, {13'd0, 1'b1, 2'b01, 16'hA5C3});
    repeat (10) tick();
    b_spi_done = 1'b1; b_spi_rx = 16'h1234;
    #1;
    chk("big_noresp_yet", {31'd0, b_resp0_valid}, 32'd0);
    tick();
    b_spi_done = 1'b0;
    #1;
    chk("big_resp", {14'd0, b_resp0_valid, b_resp_err, b_resp_data}, {14'd0, 2'b10, 16'h1234});
    tick();
    chk("big_hold", {13'd0, b_resp0_valid, b_grant, b_resp_data}, {13'd0, 3'b000, 16'h1234});

    // Round-robin under held contention from reset: req0, req1, req0, req1
    do_reset();
    req0_valid = 1'b1; req0_data = 16'h0A0A;
    req1_valid = 1'b1; req1_data = 16'h1B1B;
    xact(1'b0, 16'h0A0A, 16'h1111);
    xact(1'b1, 16'h1B1B, 16'h2222);
    xact(1'b0, 16'h0A0A, 16'h3333);
    xact(1'b1, 16'h1B1B, 16'h4444);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Timeout: resp0_valid exactly 8 cycles after spi_start, data all ones.
    // req0 is uncontended here even though it was not the last served.
    do_reset();
    req0_valid = 1'b1; req0_data = 16'hC0DE;
    #1;
    chk("tmo_ready", {31'd0, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("tmo_start", {31'd0, spi_start}, 32'd1);
    seen = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (resp0_valid && seen == 0) seen = i;
    end
    chk("tmo_latency", seen, 32'd8);
    chk("tmo_data", {15'd0, resp_err, resp_data}, {15'd0, 1'b1, 16'hFFFF});

    // spi_done coinciding with watchdog expiry: done wins
    req0_valid = 1'b1; req0_data = 16'h0F0F;
    #1;
    chk("tie_ready", {31'd0, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    repeat (7) tick();
    spi_done = 1'b1; spi_rx = 16'h5A5A;
    tick();
    spi_done = 1'b0;
    #1;
    chk("tie_resp", {14'd0, resp0_valid, resp_err, resp_data}, {14'd0, 2'b10, 16'h5A5A});
    tick();

    // Reset during WAIT drops the transaction
    req0_valid = 1'b1; req0_data = 16'h9999;
    tick();
    req0_valid = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("midrst_idle", {29'd0, grant, resp0_valid}, 32'd0);
    chk("midrst_data", {15'd0, resp_err, resp_data}, 32'd0);
    any_resp = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (resp0_valid || resp1_valid) any_resp = 1'b1;
    end
    chk("midrst_noresp", {31'd0, any_resp}, 32'd0);

    // req1 served normally afterwards
    req1_valid = 1'b1; req1_data = 16'h7777;
    #1;
    chk("post_ready", {30'd0, req1_ready, req0_ready}, 32'd2);
    tick();
    req1_valid = 1'b0;
    #1;
    chk("post_start", {14'd0, grant, spi_tx}, {14'd0, 2'b10, 16'h7777});
    tick();
    spi_done = 1'b1; spi_rx = 16'h3C3C;
    tick();
    spi_done = 1'b0;
    #1;
    chk("post_resp", {13'd0, resp1_valid, resp0_valid, resp_err, resp_data},
        {13'd0, 3'b100, 16'h3C3C});
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
